rx_descramble_depad: RTL and testbench

//  Parametrised receive-side descrambler and field stripper for the 802.11a RX chain, fed by the decoder output.

---
 rtl/rx_descramble_depad_pkg.sv | 33 +++
 rtl/rx_scrambler_step.sv | 42 ++++
 rtl/rx_descramble_depad.sv | 218 +++++++++++++++++++++
 tb/tb_rx_descramble_depad.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_descramble_depad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rx_descramble_depad_pkg                                         |
// | Purpose  : Shared definitions for the 802.11a RX descrambler / depadder:   |
// |            FSM state encodings, frame field sizes and the LFSR taps of     |
// |            the x^7 + x^4 + 1 scrambler polynomial.                         |
// | Contents : rx_state_t, c_service_bits, c_tail_bits, c_seed_bits,           |
// |            c_tap_hi, c_tap_lo, lfsr_fb()                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package rx_descramble_depad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVICE = 2'd1,
    ST_PSDU    = 2'd2,
    ST_FLUSH   = 2'd3
  } rx_state_t;

  localparam int c_service_bits = 16;
  localparam int c_tail_bits    = 6;
  localparam int c_seed_bits    = 7;

  // x^7 + x^4 + 1 taps the state at bit positions 6 and 3.
  localparam int c_tap_hi = 6;
  localparam int c_tap_lo = 3;

  function automatic logic lfsr_fb(input logic [c_seed_bits-1:0] s);
    return s[c_tap_hi] ^ s[c_tap_lo];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_scrambler_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rx_scrambler_step                                               |
// | Purpose  : Combinational W-bit unrolled step of the x^7+x^4+1 LFSR.        |
// |            Bit 0 is processed first. A bit with i_load set is shifted      |
// |            straight into the state (seed recovery) and yields d=0; any     |
// |            other bit is XORed with the feedback, which is then shifted in. |
// | Ports    : i_state [7]  current LFSR state                                 |
// |            i_bits  [W]  input bits (scrambled on RX, plain on TX)          |
// |            i_load  [W]  per-bit load mask                                  |
// |            o_state [7]  state after all W bits                             |
// |            o_bits  [W]  XORed output bits                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rx_scrambler_step
  import rx_descramble_depad_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [c_seed_bits-1:0] i_state,
  input  logic [W-1:0]           i_bits,
  input  logic [W-1:0]           i_load,
  output logic [c_seed_bits-1:0] o_state,
  output logic [W-1:0]           o_bits
);

  logic [c_seed_bits-1:0] w_chain [0:W];

  assign w_chain[0] = i_state;

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic w_fb;
    assign w_fb         = lfsr_fb(w_chain[i]);
    assign o_bits[i]    = i_load[i] ? 1'b0 : (i_bits[i] ^ w_fb);
    assign w_chain[i+1] = i_load[i] ? {w_chain[i][c_seed_bits-2:0], i_bits[i]}
                                    : {w_chain[i][c_seed_bits-2:0], w_fb};
  end

  assign o_state = w_chain[W];

endmodule
`default_nettype wire

// File: rtl/rx_descramble_depad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rx_descramble_depad                                             |
// | Purpose  : 802.11a RX descrambler and field stripper. Recovers the seed    |
// |            from the SERVICE field, descrambles W bits per beat and         |
// |            forwards only PSDU bits; SERVICE, tail and pad are dropped.     |
// | Config   : RX_TAIL_CHECK_EN - descramble the 6 tail bits and flag any      |
// |            non-zero one on tail_err (sticky per frame, shown with done).   |
// |            Undefined: tail_err is tied 0 and FLUSH beats only count.       |
// | Ports    : Clk, reset (async active-low)                                   |
// |            start, psdu_len[LEN_W], n_pad[PAD_W]   frame setup              |
// |            in_valid, in_data[W], in_ready         scrambled input stream   |
// |            out_valid, out_data[W], out_last, out_ready  PSDU output        |
// |            busy, done, seed[7], tail_err          status                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rx_descramble_depad
  import rx_descramble_depad_pkg::*;
#(
  parameter int W     = 4,
  parameter int LEN_W = 12,
  parameter int PAD_W = 8
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       psdu_len,
  input  logic [PAD_W-1:0]       n_pad,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic [c_seed_bits-1:0] seed,
  output logic                   tail_err
);

  localparam int c_cnt_w = 16 + LEN_W;

  rx_state_t              r_state;
  rx_state_t              w_state_next;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_cnt_w-1:0]     r_psdu_end;    // bit index one past the last PSDU bit
  logic [c_cnt_w-1:0]     r_frame_end;   // bit index one past the last pad bit
  logic                   r_psdu_zero;
  logic [c_seed_bits-1:0] r_lfsr;
  logic [c_seed_bits-1:0] r_seed;
  logic                   r_out_valid;
  logic [W-1:0]           r_out_data;
  logic                   r_out_last;
  logic                   r_done;

  logic                   w_in_ready;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic [c_cnt_w-1:0]     w_beat_end;
  logic [c_cnt_w-1:0]     w_psdu_end_start;
  logic [c_cnt_w-1:0]     w_frame_end_start;
  logic [W-1:0]           w_load;
  logic [W-1:0]           w_d;
  logic [c_seed_bits-1:0] w_s_next;
  logic [c_seed_bits-1:0] w_seed_next;

  assign w_in_fire  = in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_beat_end = r_cnt + c_cnt_w'(W);

  assign w_psdu_end_start  = c_cnt_w'(c_service_bits) + (c_cnt_w'(psdu_len) << 3);
  assign w_frame_end_start = w_psdu_end_start + c_cnt_w'(c_tail_bits) + c_cnt_w'(n_pad);

  // Next state and input handshake.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_SERVICE;
      end
      ST_SERVICE: begin
        w_in_ready = 1'b1;
        if (w_in_fire && (w_beat_end == c_cnt_w'(c_service_bits)))
          w_state_next = r_psdu_zero ? ST_FLUSH : ST_PSDU;
      end
      ST_PSDU: begin
        // Only take a PSDU beat when the output register is free or draining.
        w_in_ready = !r_out_valid || out_ready;
        if (w_in_fire && (w_beat_end == r_psdu_end))
          w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_in_ready = 1'b1;
        if (w_in_fire && (w_beat_end == r_frame_end))
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The first seven SERVICE bits load the LFSR; the same bits are kept as the
  // seed, earliest bit in the MSB, which matches the LFSR after the seventh load.
  always_comb begin
    w_load      = '0;
    w_seed_next = r_seed;
    for (int i = 0; i < W; i++) begin
      if ((r_state == ST_SERVICE) && ((r_cnt + c_cnt_w'(i)) < c_cnt_w'(c_seed_bits)))
        w_load[i] = 1'b1;
      for (int j = 0; j < c_seed_bits; j++) begin
        if ((r_state == ST_SERVICE) && ((r_cnt + c_cnt_w'(i)) == c_cnt_w'(j)))
          w_seed_next[c_seed_bits-1-j] = in_data[i];
      end
    end
  end

  rx_scrambler_step #(
    .W (W)
  ) u_step (
    .i_state (r_lfsr),
    .i_bits  (in_data),
    .i_load  (w_load),
    .o_state (w_s_next),
    .o_bits  (w_d)
  );

`ifdef RX_TAIL_CHECK_EN
  logic               r_tail_err;
  logic [c_cnt_w-1:0] w_tail_end;
  logic [W-1:0]       w_tail_mask;

  assign w_tail_end = r_psdu_end + c_cnt_w'(c_tail_bits);

  // FLUSH beats start at r_psdu_end, so only the upper bound needs checking.
  always_comb begin
    w_tail_mask = '0;
    for (int i = 0; i < W; i++) begin
      if ((r_state == ST_FLUSH) && ((r_cnt + c_cnt_w'(i)) < w_tail_end))
        w_tail_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_tail_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_tail_err <= 1'b0;
    end else if (w_in_fire && (r_state == ST_FLUSH)) begin
      r_tail_err <= r_tail_err | (|(w_d & w_tail_mask));
    end
  end

  assign tail_err = r_tail_err;
`else
  assign tail_err = 1'b0;
`endif

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_psdu_end  <= '0;
      r_frame_end <= '0;
      r_psdu_zero <= 1'b0;
      r_lfsr      <= '0;
      r_seed      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;

      if ((r_state == ST_IDLE) && start) begin
        r_cnt       <= '0;
        r_lfsr      <= '0;
        r_seed      <= '0;
        r_psdu_end  <= w_psdu_end_start;
        r_frame_end <= w_frame_end_start;
        r_psdu_zero <= (psdu_len == '0);
      end

      if (w_in_fire) begin
        r_cnt  <= w_beat_end;
        r_seed <= w_seed_next;
`ifdef RX_TAIL_CHECK_EN
        r_lfsr <= w_s_next;
`else
        if (r_state != ST_FLUSH) r_lfsr <= w_s_next;
`endif
        if ((r_state == ST_FLUSH) && (w_beat_end == r_frame_end))
          r_done <= 1'b1;
      end

      // PSDU beats are aligned to W because 16 and 8*psdu_len are multiples of W.
      if (w_in_fire && (r_state == ST_PSDU)) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_d;
        r_out_last  <= (w_beat_end == r_psdu_end);
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign seed      = r_seed;

endmodule
`default_nettype wire

// File: tb/tb_rx_descramble_depad.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_rx_descramble_depad                                          |
// | Purpose  : Directed self-checking bench for rx_descramble_depad with one   |
// |            W=1 and one W=4 instance. Frames are built by a serial TX       |
// |            scrambler model; the expected output is the chosen PSDU.        |
// | Config   : RX_TAIL_CHECK_EN selects the expected tail_err value.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rx_descramble_depad;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;
    logic reset;

    logic        start4, iv4, ir4, ov4, ol4, ordy4, busy4, done4, te4;
    logic [11:0] len4;
    logic [7:0]  pad4;
    logic [3:0]  id4, od4;
    logic [6:0]  seed4;

    logic        start1, iv1, ir1, ov1, ol1, ordy1, busy1, done1, te1;
    logic [11:0] len1;
    logic [7:0]  pad1;
    logic [0:0]  id1, od1;
    logic [6:0]  seed1;

    rx_descramble_depad #(.W(4), .LEN_W(12), .PAD_W(8)) u_dut4 (
        .Clk(Clk), .reset(reset), .start(start4), .psdu_len(len4), .n_pad(pad4),
        .in_valid(iv4), .in_data(id4), .in_ready(ir4),
        .out_valid(ov4), .out_data(od4), .out_last(ol4), .out_ready(ordy4),
        .busy(busy4), .done(done4), .seed(seed4), .tail_err(te4)
    );

    rx_descramble_depad #(.W(1), .LEN_W(12), .PAD_W(8)) u_dut1 (
        .Clk(Clk), .reset(reset), .start(start1), .psdu_len(len1), .n_pad(pad1),
        .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_last(ol1), .out_ready(ordy1),
        .busy(busy1), .done(done1), .seed(seed1), .tail_err(te1)
    );

`ifdef RX_TAIL_CHECK_EN
    localparam logic c_flip_te = 1'b1;
`else
    localparam logic c_flip_te = 1'b0;
`endif

    logic       air [0:2047];
    int         n_air;
    logic [7:0] psdu_b [0:15];

    task automatic build_frame(input logic [6:0] sd, input int len, input int pad, input int flip);
        logic [6:0] s;
        logic       pl, f;
        int         pend;
        pend  = 16 + 8*len;
        n_air = pend + 6 + pad;
        s     = sd;
        for (int k = 0; k < n_air; k++) begin
            if (k < 7) air[k] = sd[6-k];
            else begin
                pl = (k >= 16 && k < pend) ? psdu_b[(k-16)/8][(k-16)%8] : 1'b0;
                f  = s[6] ^ s[3];
                air[k] = pl ^ f;
                s = {s[5:0], f};
            end
        end
        if (flip >= 0) air[pend+flip] = ~air[pend+flip];
    endtask

    function automatic logic [3:0] air_nib(input int p);
        if (4*p+3 < n_air) return {air[4*p+3], air[4*p+2], air[4*p+1], air[4*p]};
        return 4'h0;
    endfunction

    task automatic run4(input int len, input int pad, input int stall_from, input int stall_to,
                        input int abort_ptr, input logic [6:0] exp_seed, input logic exp_te);
        int ptr = 0, cyc = 0, nout = 0, n_done = 0, n_beats, pbeats;
        logic fin_prev = 1'b0, fin_now, acc_in, acc_out, hold = 1'b0, hl;
        logic [3:0] hd, exp_n;
        bit ended = 0;
        n_beats = n_air / 4;
        pbeats  = 2*len;
        @(negedge Clk);
        start4 = 1'b1; len4 = 12'(len); pad4 = 8'(pad);
        iv4 = 1'b1; id4 = air_nib(0); ordy4 = 1'b1;
        #1;
        chk("start_cycle_in_ready", ir4, 1'b0);
        @(posedge Clk); #1;
        start4 = 1'b0;
        chk("busy_after_start", busy4, 1'b1);
        while (!ended) begin
            @(negedge Clk);
            iv4   = (ptr < n_beats);
            id4   = air_nib(ptr);
            ordy4 = !(cyc >= stall_from && cyc <= stall_to);
            #1;
            chk("done_timing", done4, fin_prev);
            if (done4) begin
                n_done++;
                chk("tail_err", te4, exp_te);
                chk("seed", seed4, exp_seed);
            end
            if (hold) begin
                chk("hold_valid", ov4, 1'b1);
                chk("hold_data", od4, hd);
                chk("hold_last", ol4, hl);
            end
            hold = ov4 && !ordy4; hd = od4; hl = ol4;
            if (!ordy4 && ov4 && ptr >= 4 && ptr < 4 + pbeats)
                chk("stall_in_ready", ir4, 1'b0);
            acc_in  = iv4 && ir4;
            acc_out = ov4 && ordy4;
            if (acc_out) begin
                exp_n = 4'(psdu_b[nout/2] >> (4*(nout%2)));
                chk("out_data", od4, exp_n);
                chk("out_last", ol4, (nout == pbeats-1));
                nout++;
            end
            fin_now = acc_in && (ptr == n_beats-1);
            @(posedge Clk); #1;
            if (acc_in) ptr++;
            fin_prev = fin_now;
            cyc++;
            if (abort_ptr >= 0 && ptr >= abort_ptr) begin
                iv4 = 1'b0;
                return;
            end
            if (n_done > 0 && !ov4) ended = 1;
            if (cyc > 200) begin
                chk("cycle_budget", cyc, 200);
                ended = 1;
            end
        end
        iv4 = 1'b0;
        chk("out_beats", nout, pbeats);
        chk("done_count", n_done, 1);
    endtask

    task automatic run1(input int len, input logic [6:0] exp_seed);
        int ptr = 0, cyc = 0, nout = 0, n_done = 0;
        logic fin_prev = 1'b0, fin_now, acc_in;
        bit ended = 0;
        @(negedge Clk);
        start1 = 1'b1; len1 = 12'(len); pad1 = 8'd0; iv1 = 1'b0; ordy1 = 1'b1;
        @(posedge Clk); #1;
        start1 = 1'b0;
        while (!ended) begin
            @(negedge Clk);
            iv1 = (ptr < n_air);
            id1 = (ptr < n_air) ? air[ptr] : 1'b0;
            #1;
            chk("w1_done_timing", done1, fin_prev);
            if (done1) begin
                n_done++;
                chk("w1_seed", seed1, exp_seed);
            end
            if (ov1) begin
                chk("w1_out_data", od1[0], psdu_b[nout/8][nout%8]);
                chk("w1_out_last", ol1, (nout == 8*len-1));
                nout++;
            end
            acc_in  = iv1 && ir1;
            fin_now = acc_in && (ptr == n_air-1);
            @(posedge Clk); #1;
            if (acc_in) ptr++;
            fin_prev = fin_now;
            cyc++;
            if (n_done > 0 && !ov1) ended = 1;
            if (cyc > 100) begin
                chk("w1_cycle_budget", cyc, 100);
                ended = 1;
            end
        end
        iv1 = 1'b0;
        chk("w1_out_bits", nout, 8*len);
        chk("w1_done_count", n_done, 1);
    endtask

    initial begin
        reset = 1'b0;
        start4 = 1'b0; len4 = '0; pad4 = '0; iv4 = 1'b0; id4 = '0; ordy4 = 1'b1;
        start1 = 1'b0; len1 = '0; pad1 = '0; iv1 = 1'b0; id1 = '0; ordy1 = 1'b1;
        #12;
        chk("rst_out_valid", ov4, 1'b0);
        chk("rst_out_data", od4, 4'h0);
        chk("rst_out_last", ol4, 1'b0);
        chk("rst_in_ready", ir4, 1'b0);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_done", done4, 1'b0);
        chk("rst_seed", seed4, 7'h00);
        chk("rst_tail_err", te4, 1'b0);
        chk("rst_w1_busy", busy1, 1'b0);
        @(negedge Clk);
        reset = 1'b1;

        psdu_b[0] = 8'hA5;
        build_frame(7'b1011101, 1, 0, -1);
        run1(1, 7'b1011101);

        psdu_b[0] = 8'h3C; psdu_b[1] = 8'h96; psdu_b[2] = 8'hE1;
        build_frame(7'b1101001, 3, 14, -1);
        run4(3, 14, -1, -1, -1, 7'b1101001, 1'b0);

        psdu_b[0] = 8'h5A; psdu_b[1] = 8'hF0; psdu_b[2] = 8'h0F; psdu_b[3] = 8'h81;
        build_frame(7'b0110011, 4, 2, -1);
        run4(4, 2, 6, 10, -1, 7'b0110011, 1'b0);

        build_frame(7'b1111111, 0, 2, -1);
        run4(0, 2, -1, -1, -1, 7'b1111111, 1'b0);

        psdu_b[0] = 8'h12; psdu_b[1] = 8'h34; psdu_b[2] = 8'h56;
        build_frame(7'b1000001, 3, 14, -1);
        run4(3, 14, -1, -1, 6, 7'b1000001, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_out_valid", ov4, 1'b0);
        chk("midrst_out_data", od4, 4'h0);
        chk("midrst_out_last", ol4, 1'b0);
        chk("midrst_in_ready", ir4, 1'b0);
        chk("midrst_busy", busy4, 1'b0);
        chk("midrst_seed", seed4, 7'h00);
        @(negedge Clk);
        reset = 1'b1;
        psdu_b[0] = 8'hC7; psdu_b[1] = 8'h2B; psdu_b[2] = 8'h90;
        build_frame(7'b0101010, 3, 14, -1);
        run4(3, 14, -1, -1, -1, 7'b0101010, 1'b0);

        psdu_b[0] = 8'h6E; psdu_b[1] = 8'hB3;
        build_frame(7'b0011100, 2, 2, 3);
        run4(2, 2, -1, -1, -1, 7'b0011100, c_flip_te);
        build_frame(7'b0011100, 2, 2, -1);
        run4(2, 2, -1, -1, -1, 7'b0011100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
